csr_out_fifo: RTL and testbench

- CSR-mapped output port with an internal FIFO. The CPU pushes words through the CSR bus (cadr/coe/cwe/cvalid/cdat).
- A downstream consumer drains the words over a valid/ready stream.
- Successor to the single-register output CSR. Adds parametrised data width, buffer depth and base address, plus status, sticky overflow and flush.
- Sits beside the CPU's CSR port in the system top.

---
 rtl/csr_out_fifo.sv | 136 +++++++++++++
 tb/tb_csr_out_fifo.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/csr_out_fifo.sv
// CSR-mapped output port with an internal FIFO: the CPU pushes words through the CSR bus,
// a downstream consumer drains them over a valid/ready stream.
module csr_out_fifo #(
    parameter logic [11:0] CSR_BASE = 12'h780,
    parameter int          DATA_W   = 64,
    parameter int          DEPTH    = 16
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic [11:0]       cadr_i,
    input  logic              coe_i,
    input  logic              cwe_i,
    input  logic [63:0]       cdat_i,
    output logic [63:0]       cdat_o,
    output logic              cvalid_o,
    output logic [DATA_W-1:0] out_dat_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              irq_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr_reg, rd_ptr_next;
    logic [AW-1:0]     wr_ptr_reg, wr_ptr_next;
    logic [AW:0]       count_reg, count_next;
    logic              ovf_reg, ovf_next;
    logic [DATA_W-1:0] head_reg, head_next;
    logic [63:0]       head_ext;
    logic [63:0]       status;

    logic hit_data, hit_status, hit_ctrl;
    logic wr_data, wr_ctrl, flush, ovf_clr;
    logic empty, full, pop, push_ok, push_drop;

    assign hit_data   = (cadr_i == CSR_BASE);
    assign hit_status = (cadr_i == CSR_BASE + 12'd1);
    assign hit_ctrl   = (cadr_i == CSR_BASE + 12'd2);
    assign cvalid_o   = (hit_data | hit_status | hit_ctrl) & (coe_i | cwe_i);

    assign wr_data = cwe_i & hit_data;
    assign wr_ctrl = cwe_i & hit_ctrl;
    assign flush   = wr_ctrl & cdat_i[0];
    assign ovf_clr = wr_ctrl & cdat_i[1];

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == (AW+1)'(DEPTH));
    assign pop       = ~empty & out_ready_i;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_ok   = wr_data & (~full | pop);
    assign push_drop = wr_data & full & ~pop;

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        ovf_next    = ovf_reg;
        if (flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (pop)
                rd_ptr_next = rd_ptr_reg + 1'b1;
            if (push_ok)
                wr_ptr_next = wr_ptr_reg + 1'b1;
            if (push_ok && !pop)
                count_next = count_reg + 1'b1;
            else if (pop && !push_ok)
                count_next = count_reg - 1'b1;
        end
        if (ovf_clr)
            ovf_next = 1'b0;
        if (push_drop)
            ovf_next = 1'b1;
    end

    // The pushed word becomes the head only when it lands on the next read slot.
    always_comb begin
        head_next = '0;
        if (count_next != '0) begin
            if (push_ok && (wr_ptr_reg == rd_ptr_next))
                head_next = cdat_i[DATA_W-1:0];
            else
                head_next = mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_ni && push_ok)
            mem[wr_ptr_reg] <= cdat_i[DATA_W-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
            head_reg   <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            ovf_reg    <= ovf_next;
            head_reg   <= head_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_head_ext
            if (gi < DATA_W) begin : g_bit
                assign head_ext[gi] = head_reg[gi];
            end else begin : g_pad
                assign head_ext[gi] = 1'b0;
            end
        end
    endgenerate

    assign status = {39'b0, 9'(count_reg), 13'b0, ovf_reg, full, empty};

    always_comb begin
        cdat_o = '0;
        if (coe_i) begin
            if (hit_data)
                cdat_o = head_ext;
            else if (hit_status)
                cdat_o = status;
        end
    end

    assign out_dat_o   = head_reg;
    assign out_valid_o = ~empty;
    assign irq_o       = ovf_reg;
endmodule

// File: tb/tb_csr_out_fifo.sv
// Directed bench for csr_out_fifo: fill, drain, overflow, full push+pop, flush, reset, miss.
module tb_csr_out_fifo;
    logic        clk = 1'b0;
    logic        reset_ni = 1'b0;
    logic [11:0] cadr = '0;
    logic        coe = 1'b0;
    logic        cwe = 1'b0;
    logic [63:0] cdat_in = '0;
    logic [63:0] cdat_out;
    logic        cvalid;
    logic [63:0] out_dat;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        irq;

    int checks = 0;
    int errors = 0;

    csr_out_fifo dut (
        .clk_i      (clk),
        .reset_ni   (reset_ni),
        .cadr_i     (cadr),
        .coe_i      (coe),
        .cwe_i      (cwe),
        .cdat_i     (cdat_in),
        .cdat_o     (cdat_out),
        .cvalid_o   (cvalid),
        .out_dat_o  (out_dat),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-16s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [63:0] d);
        cadr = a; cdat_in = d; cwe = 1'b1;
        tick();
        cwe = 1'b0; cadr = '0; cdat_in = '0;
    endtask

    task automatic csr_read(input string tag, input logic [11:0] a, input logic [63:0] exp);
        cadr = a; coe = 1'b1;
        #1;
        chk(tag, cdat_out, exp);
        coe = 1'b0; cadr = '0;
        #1;
    endtask

    initial begin
        // Reset
        repeat (3) tick();
        reset_ni = 1'b1;
        cadr = 12'h781; coe = 1'b1; #1;
        chk("rst_status", cdat_out, 64'h1);
        chk("rst_cvalid", 64'(cvalid), 64'h1);
        coe = 1'b0; cadr = '0;
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_dat", out_dat, 64'h0);
        chk("rst_irq", 64'(irq), 64'h0);

        // Four words, then drain in order
        for (int i = 1; i <= 4; i++) csr_write(12'h780, 64'hDEAD_BEEF_0000_0000 + 64'(i));
        csr_read("fill4_status", 12'h781, 64'h0004_0000);
        csr_read("fill4_data", 12'h780, 64'hDEAD_BEEF_0000_0001);
        csr_read("fill4_nopop", 12'h781, 64'h0004_0000);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_valid", 64'(out_valid), 64'h1);
            chk("drain_dat", out_dat, 64'hDEAD_BEEF_0000_0000 + 64'(i));
            tick();
        end
        out_ready = 1'b0;
        chk("drain_empty", 64'(out_valid), 64'h0);
        csr_read("drain_data0", 12'h780, 64'h0);

        // Overflow: 17 writes into 16 entries
        for (int i = 0; i < 17; i++) csr_write(12'h780, 64'h1000 + 64'(i));
        csr_read("ovf_status", 12'h781, 64'h0010_0006);
        chk("ovf_irq", 64'(irq), 64'h1);
        csr_write(12'h782, 64'h2);
        chk("ovf_clr_irq", 64'(irq), 64'h0);
        csr_read("ovf_clr_status", 12'h781, 64'h0010_0002);

        // Push while full with a pop on the same edge
        out_ready = 1'b1;
        csr_write(12'h780, 64'h2000);
        out_ready = 1'b0;
        csr_read("fullpp_status", 12'h781, 64'h0010_0002);
        chk("fullpp_irq", 64'(irq), 64'h0);
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk("fullpp_order", out_dat, (i == 16) ? 64'h2000 : 64'h1000 + 64'(i));
            tick();
        end
        out_ready = 1'b0;
        chk("fullpp_empty", 64'(out_valid), 64'h0);

        // Write 8, drain 3, flush, push after flush
        for (int i = 0; i < 8; i++) csr_write(12'h780, 64'h3000 + 64'(i));
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("part_drain", out_dat, 64'h3000 + 64'(i));
            tick();
        end
        out_ready = 1'b0;
        csr_read("part_status", 12'h781, 64'h0005_0000);
        csr_write(12'h782, 64'h1);
        chk("flush_valid", 64'(out_valid), 64'h0);
        csr_read("flush_status", 12'h781, 64'h1);
        csr_write(12'h780, 64'h55);
        chk("postflush_valid", 64'(out_valid), 64'h1);
        chk("postflush_dat", out_dat, 64'h55);

        // Reset with 5 entries held and a push in flight
        for (int i = 0; i < 4; i++) csr_write(12'h780, 64'h4000 + 64'(i));
        csr_read("pre_rst_status", 12'h781, 64'h0005_0000);
        cadr = 12'h780; cdat_in = 64'h99; cwe = 1'b1; reset_ni = 1'b0;
        tick();
        cwe = 1'b0; cadr = '0; cdat_in = '0; reset_ni = 1'b1;
        csr_read("midrst_status", 12'h781, 64'h1);
        chk("midrst_valid", 64'(out_valid), 64'h0);
        chk("midrst_dat", out_dat, 64'h0);
        chk("midrst_irq", 64'(irq), 64'h0);

        // Address miss and write-only CONTROL readback
        cadr = 12'h783; coe = 1'b1; #1;
        chk("miss_cvalid", 64'(cvalid), 64'h0);
        chk("miss_cdat", cdat_out, 64'h0);
        cadr = 12'h782; #1;
        chk("ctrl_cvalid", 64'(cvalid), 64'h1);
        chk("ctrl_cdat", cdat_out, 64'h0);
        coe = 1'b0; cadr = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
